ltssm_link_coordinator: RTL

//  Next-generation LTSSM coordinator between the Tx/Rx LTSSM substate engines and the LPIF side.

---
 rtl/ltssm_pkg.sv | 35 +++
 rtl/ltssm_link_coordinator_if.sv | 36 +++
 rtl/ltssm_timeout_timer.sv | 26 ++
 rtl/ltssm_link_coordinator.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// rtl/ltssm_pkg.sv - shared substate, LPIF and handshake encodings for the LTSSM coordinator
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET  = 4'd0,
    DETECT_ACTIVE = 4'd1,
    POLL_ACTIVE   = 4'd2,
    POLL_CFG      = 4'd3,
    CFG_LW_START  = 4'd4,
    CFG_LW_ACCEPT = 4'd5,
    CFG_LN_WAIT   = 4'd6,
    CFG_LN_ACCEPT = 4'd7,
    CFG_COMPLETE  = 4'd8,
    CFG_IDLE      = 4'd9,
    L0            = 4'd10,
    REC_RCVRLOCK  = 4'd11,
    REC_RCVRCFG   = 4'd12,
    REC_IDLE      = 4'd13
  } substate_e;

  typedef enum logic [1:0] {HS_NONE, HS_RX, HS_TX, HS_JOINT} hs_mode_e;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd11;

  function automatic logic [1:0] pipewidth_to_code(input int pw);
    case (pw)
      16:      return 2'd1;
      32:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ltssm_link_coordinator_if.sv
// rtl/ltssm_link_coordinator_if.sv - substate-engine / LPIF signal bundle for the coordinator
interface ltssm_link_coordinator_if #(parameter int LW = 5);
  logic          forceDetect;
  logic [3:0]    lpifStateRequest;
  logic          finishTx, finishRx;
  logic [3:0]    gotoTx, gotoRx;
  logic [LW-1:0] numberOfDetectedLanesIn;
  logic          writeNumberOfDetectedLanes;
  logic [7:0]    linkNumberInTx, linkNumberInRx;
  logic          writeLinkNumberTx, writeLinkNumberRx;
  logic [7:0]    rateIdIn;
  logic          writeRateId;
  logic [3:0]    substateTx, substateRx;
  logic [3:0]    lpifStateStatus;
  logic          linkUp;
  logic [2:0]    GEN;
  logic [1:0]    width;
  logic [LW-1:0] numberOfDetectedLanesOut;
  logic [7:0]    linkNumberOut, rateIdOut;

  modport master (
    output forceDetect, lpifStateRequest, finishTx, finishRx, gotoTx, gotoRx,
           numberOfDetectedLanesIn, writeNumberOfDetectedLanes, linkNumberInTx, linkNumberInRx,
           writeLinkNumberTx, writeLinkNumberRx, rateIdIn, writeRateId,
    input  substateTx, substateRx, lpifStateStatus, linkUp, GEN, width,
           numberOfDetectedLanesOut, linkNumberOut, rateIdOut
  );

  modport slave (
    input  forceDetect, lpifStateRequest, finishTx, finishRx, gotoTx, gotoRx,
           numberOfDetectedLanesIn, writeNumberOfDetectedLanes, linkNumberInTx, linkNumberInRx,
           writeLinkNumberTx, writeLinkNumberRx, rateIdIn, writeRateId,
    output substateTx, substateRx, lpifStateStatus, linkUp, GEN, width,
           numberOfDetectedLanesOut, linkNumberOut, rateIdOut
  );
endinterface

// File: rtl/ltssm_timeout_timer.sv
// rtl/ltssm_timeout_timer.sv - per-substate dwell counter, expires after TIMEOUT_CYCLES-1 counted cycles
module ltssm_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expire) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/ltssm_link_coordinator.sv
// rtl/ltssm_link_coordinator.sv - shared Tx/Rx LTSSM substate, LPIF status, Recovery and rate change
// Optional substate timeout is built when LTSSM_TIMEOUT_EN is defined.
module ltssm_link_coordinator
  import ltssm_pkg::*;
#(
  parameter int DEVICETYPE     = 0,
  parameter int MAX_LANES      = 16,
  parameter int MAX_GEN        = 5,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input logic                     clk,
  input logic                     reset,
  ltssm_link_coordinator_if.slave bus
);
  localparam int LW = $clog2(MAX_LANES) + 1;

  substate_e     state, state_nx, nxt;
  hs_mode_e      mode;
  logic [3:0]    status, status_nx;
  logic          link_up, link_up_nx;
  logic [2:0]    gen, gen_nx, rate_gen;
  logic [1:0]    width;
  logic [LW-1:0] lanes;
  logic [7:0]    link_num, rate_id;
  logic          rx_ok, tx_ok, adv, fallback, bad_state, timeout;

  function automatic int gen_pipewidth(input logic [2:0] g);
    case (g)
      3'd2:    return GEN2_PIPEWIDTH;
      3'd3:    return GEN3_PIPEWIDTH;
      3'd4:    return GEN4_PIPEWIDTH;
      3'd5:    return GEN5_PIPEWIDTH;
      default: return GEN1_PIPEWIDTH;
    endcase
  endfunction

`ifdef LTSSM_TIMEOUT_EN
  ltssm_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_nx != state),
    .enable (state != DETECT_QUIET && state != L0),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign rate_gen = rate_id[2:0];

  always_comb begin
    state_nx   = state;
    status_nx  = status;
    link_up_nx = link_up;
    gen_nx     = gen;
    nxt        = DETECT_QUIET;
    mode       = HS_NONE;
    bad_state  = 1'b0;
    case (state)
      DETECT_QUIET, POLL_ACTIVE, CFG_LW_START, CFG_LN_WAIT, CFG_LN_ACCEPT: begin
        nxt  = substate_e'(state + 4'd1);
        mode = HS_RX;
      end
      DETECT_ACTIVE, POLL_CFG, CFG_COMPLETE, CFG_IDLE, REC_RCVRLOCK, REC_RCVRCFG: begin
        nxt  = substate_e'(state + 4'd1);
        mode = HS_JOINT;
      end
      CFG_LW_ACCEPT: begin
        nxt  = CFG_LN_WAIT;
        mode = (DEVICETYPE == 0) ? HS_TX : HS_JOINT;
      end
      REC_IDLE: begin
        nxt  = L0;
        mode = HS_JOINT;
      end
      L0:      ;
      default: bad_state = 1'b1;
    endcase

    rx_ok = bus.finishRx && (bus.gotoRx == nxt);
    tx_ok = bus.finishTx && (bus.gotoTx == nxt);
    case (mode)
      HS_RX:    adv = rx_ok;
      HS_TX:    adv = tx_ok;
      HS_JOINT: adv = rx_ok && tx_ok;
      default:  adv = 1'b0;
    endcase
    // Link-up waits in CFG_IDLE until the LPIF side asks for ACTIVE.
    if (state == CFG_IDLE && bus.lpifStateRequest != LPIF_ACTIVE) adv = 1'b0;

    fallback = (bus.finishTx && bus.gotoTx == DETECT_QUIET) ||
               (bus.finishRx && bus.gotoRx == DETECT_QUIET);

    if (bus.forceDetect || timeout || fallback || bad_state ||
        (state == L0 && bus.lpifStateRequest == LPIF_RESET)) begin
      state_nx   = DETECT_QUIET;
      status_nx  = LPIF_RESET;
      link_up_nx = 1'b0;
      gen_nx     = 3'd1;
    end else if (state == L0) begin
      if (bus.lpifStateRequest == LPIF_RETRAIN) begin
        state_nx  = REC_RCVRLOCK;
        status_nx = LPIF_RETRAIN;
      end
    end else if (adv) begin
      state_nx = nxt;
      if (nxt == L0) begin
        link_up_nx = 1'b1;
        status_nx  = LPIF_ACTIVE;
      end
      if (state == REC_IDLE && rate_gen != 3'd0)
        gen_nx = (rate_gen > 3'(MAX_GEN)) ? 3'(MAX_GEN) : rate_gen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DETECT_QUIET;
      status   <= LPIF_RESET;
      link_up  <= 1'b0;
      gen      <= 3'd1;
      width    <= pipewidth_to_code(GEN1_PIPEWIDTH);
      lanes    <= '0;
      link_num <= '0;
      rate_id  <= '0;
    end else begin
      state   <= state_nx;
      status  <= status_nx;
      link_up <= link_up_nx;
      gen     <= gen_nx;
      width   <= pipewidth_to_code(gen_pipewidth(gen));
      if (bus.writeNumberOfDetectedLanes) lanes <= bus.numberOfDetectedLanesIn;
      if (bus.writeLinkNumberTx)          link_num <= bus.linkNumberInTx;
      else if (bus.writeLinkNumberRx)     link_num <= bus.linkNumberInRx;
      if (bus.writeRateId)                rate_id <= bus.rateIdIn;
    end
  end

  assign bus.substateTx               = state;
  assign bus.substateRx               = state;
  assign bus.lpifStateStatus          = status;
  assign bus.linkUp                   = link_up;
  assign bus.GEN                      = gen;
  assign bus.width                    = width;
  assign bus.numberOfDetectedLanesOut = lanes;
  assign bus.linkNumberOut            = link_num;
  assign bus.rateIdOut                = rate_id;
endmodule
